// File: rtl/satarx_crc_check.sv
// Receive-side SATA CRC checker/stripper: holds one dword back so the trailing CRC
// can be compared and removed, and ends every packet with either TLAST or TABORT.
module satarx_crc_check #(
  parameter bit          OPT_LOWPOWER = 1'b0,
  parameter int          LGMAXLEN     = 12,
  parameter logic [31:0] INITIAL_CRC  = 32'h5232_5032,
  parameter logic [31:0] POLYNOMIAL   = 32'h04C1_1DB7
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESETN,
  input  logic        i_cfg_crc_en,
  input  logic        S_AXIS_TVALID,
  input  logic [31:0] S_AXIS_TDATA,
  input  logic        S_AXIS_TLAST,
  output logic        M_AXIS_TVALID,
  output logic [31:0] M_AXIS_TDATA,
  output logic        M_AXIS_TLAST,
  output logic        M_AXIS_TABORT,
  output logic [15:0] o_err_count,
  output logic [1:0]  o_abort_cause
);

  typedef enum logic [1:0] {IDLE, PASS, HOLD, DROP} state_t;

  localparam logic [1:0] CAUSE_CRC  = 2'b01;
  localparam logic [1:0] CAUSE_RUNT = 2'b10;
  localparam logic [1:0] CAUSE_LEN  = 2'b11;
  // Beat count at which a further non-TLAST beat exceeds the length limit.
  localparam logic [LGMAXLEN:0] MAXLEN = {1'b1, {LGMAXLEN{1'b0}}};

  state_t              state, state_d;
  logic [31:0]         crc, crc_d;
  logic [31:0]         hold, hold_d;
  logic [LGMAXLEN:0]   n, n_d;
  logic                vld_d, last_d, abort_d;
  logic [31:0]         data_d;
  logic [1:0]          cause_d;
  logic [15:0]         cnt_d;

  // 32 bits per dword, MSB first.
  function automatic logic [31:0] crc_adv(input logic [31:0] c, input logic [31:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 31; i >= 0; i--) begin
      fb = r[31] ^ d[i];
      r  = {r[30:0], 1'b0} ^ (fb ? POLYNOMIAL : 32'h0);
    end
    return r;
  endfunction

  always_comb begin
    state_d = state;
    crc_d   = crc;
    hold_d  = hold;
    n_d     = n;
    vld_d   = 1'b0;
    last_d  = 1'b0;
    abort_d = 1'b0;
    data_d  = OPT_LOWPOWER ? 32'h0 : M_AXIS_TDATA;
    cause_d = o_abort_cause;
    if (S_AXIS_TVALID) begin
      case (state)
        IDLE: begin
          if (!i_cfg_crc_en) begin
            vld_d  = 1'b1;
            data_d = S_AXIS_TDATA;
            last_d = S_AXIS_TLAST;
            n_d    = 1;
            if (!S_AXIS_TLAST) state_d = PASS;
          end else if (S_AXIS_TLAST) begin
            abort_d = 1'b1;
            cause_d = CAUSE_RUNT;
          end else begin
            hold_d  = S_AXIS_TDATA;
            crc_d   = crc_adv(INITIAL_CRC, S_AXIS_TDATA);
            n_d     = 1;
            state_d = HOLD;
          end
        end
        PASS: begin
          if (n == MAXLEN && !S_AXIS_TLAST) begin
            abort_d = 1'b1;
            cause_d = CAUSE_LEN;
            state_d = DROP;
          end else begin
            vld_d  = 1'b1;
            data_d = S_AXIS_TDATA;
            last_d = S_AXIS_TLAST;
            n_d    = n + 1'b1;
            if (S_AXIS_TLAST) state_d = IDLE;
          end
        end
        HOLD: begin
          if (n == MAXLEN && !S_AXIS_TLAST) begin
            abort_d = 1'b1;
            cause_d = CAUSE_LEN;
            state_d = DROP;
          end else if (!S_AXIS_TLAST) begin
            vld_d  = 1'b1;
            data_d = hold;
            hold_d = S_AXIS_TDATA;
            crc_d  = crc_adv(crc, S_AXIS_TDATA);
            n_d    = n + 1'b1;
          end else if (S_AXIS_TDATA == crc) begin
            vld_d   = 1'b1;
            data_d  = hold;
            last_d  = 1'b1;
            state_d = IDLE;
          end else begin
            abort_d = 1'b1;
            cause_d = CAUSE_CRC;
            state_d = IDLE;
          end
        end
        DROP: if (S_AXIS_TLAST) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    if (state_d == IDLE) begin
      crc_d = INITIAL_CRC;
      n_d   = '0;
    end
    cnt_d = o_err_count;
    if (abort_d && o_err_count != 16'hFFFF) cnt_d = o_err_count + 16'd1;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state         <= IDLE;
      crc           <= INITIAL_CRC;
      n             <= '0;
      hold          <= '0;
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TDATA  <= '0;
      M_AXIS_TLAST  <= 1'b0;
      M_AXIS_TABORT <= 1'b0;
      o_err_count   <= '0;
      o_abort_cause <= '0;
    end else begin
      state         <= state_d;
      crc           <= crc_d;
      n             <= n_d;
      hold          <= hold_d;
      M_AXIS_TVALID <= vld_d;
      M_AXIS_TDATA  <= data_d;
      M_AXIS_TLAST  <= last_d;
      M_AXIS_TABORT <= abort_d;
      o_err_count   <= cnt_d;
      o_abort_cause <= cause_d;
    end
  end

endmodule

// File: tb/tb_satarx_crc_check.sv
// Packet-level bench for satarx_crc_check: a packet table drives stimulus, expected
// beats/aborts go into a queue, and a monitor pops and compares each DUT output.
module tb_satarx_crc_check;
  localparam int          LG   = 3;
  localparam int          MAXB = 8;
  localparam logic [31:0] SEED = 32'h5232_5032;

  logic        clk = 1'b0, rst_n = 1'b0, cfg = 1'b0;
  logic        s_valid = 1'b0, s_last = 1'b0;
  logic [31:0] s_data = '0;
  logic        m_valid, m_last, m_abort;
  logic [31:0] m_data;
  logic [15:0] err_count;
  logic [1:0]  cause;

  always #5 clk = ~clk;

  satarx_crc_check #(.OPT_LOWPOWER(1'b0), .LGMAXLEN(LG)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .i_cfg_crc_en(cfg),
    .S_AXIS_TVALID(s_valid), .S_AXIS_TDATA(s_data), .S_AXIS_TLAST(s_last),
    .M_AXIS_TVALID(m_valid), .M_AXIS_TDATA(m_data), .M_AXIS_TLAST(m_last),
    .M_AXIS_TABORT(m_abort), .o_err_count(err_count), .o_abort_cause(cause)
  );

  typedef struct {
    bit         en;
    int         len;
    bit         bad;
    bit         gaps;
    bit         tog;
    bit         pat;
    int         nout;
    logic [1:0] cause;
  } vec_t;

  typedef struct {
    bit          ab;
    logic [31:0] d;
    bit          l;
    logic [1:0]  c;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          checks = 0, failures = 0;
  logic [15:0] exp_err = '0;
  bit          mon_en = 1'b0;
  vec_t        tbl[13];

  // Data-first Galois form, equivalent to bitwise MSB-first over a whole dword.
  function automatic logic [31:0] model_crc(input logic [31:0] c, input logic [31:0] d);
    logic [31:0] r;
    r = c ^ d;
    for (int i = 0; i < 32; i++) r = r[31] ? ((r << 1) ^ 32'h04C1_1DB7) : (r << 1);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (m_valid || m_abort) begin
        chk("valid_abort_excl", {31'b0, m_valid & m_abort}, 32'h0);
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: valid=%b abort=%b data=%h, expected nothing", m_valid, m_abort, m_data);
        end else begin
          mon_e = sbq.pop_front();
          chk("kind_abort", {31'b0, m_abort}, {31'b0, mon_e.ab});
          if (mon_e.ab) begin
            if (exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
            chk("abort_cause", {30'b0, cause}, {30'b0, mon_e.c});
            chk("err_count", {16'b0, err_count}, {16'b0, exp_err});
          end else begin
            chk("tdata", m_data, mon_e.d);
            chk("tlast", {31'b0, m_last}, {31'b0, mon_e.l});
          end
        end
      end else begin
        chk("idle_tlast", {31'b0, m_last}, 32'h0);
      end
    end
  end

  task automatic idle_beat();
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = $urandom;
  endtask

  task automatic send_pkt(input vec_t v);
    logic [31:0] w[$];
    logic [31:0] c;
    logic [31:0] t;
    exp_t        e;
    for (int i = 0; i < v.len; i++) begin
      t = v.pat ? $urandom : (i + 1) * 32'h1111_1111;
      w.push_back(t);
    end
    if (v.en && v.len >= 2 && v.len <= MAXB) begin
      c = SEED;
      for (int i = 0; i < v.len - 1; i++) c = model_crc(c, w[i]);
      w[v.len - 1] = c ^ (v.bad ? 32'h1 : 32'h0);
    end
    for (int i = 0; i < v.nout; i++) begin
      e = '{1'b0, w[i], (v.cause == 2'b00 && i == v.nout - 1), 2'b00};
      sbq.push_back(e);
    end
    if (v.cause != 2'b00) begin
      e = '{1'b1, 32'h0, 1'b0, v.cause};
      sbq.push_back(e);
    end
    for (int i = 0; i < v.len; i++) begin
      if (v.gaps && i > 0) repeat ($urandom_range(0, 2)) idle_beat();
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = w[i];
      s_last  = (i == v.len - 1);
      cfg     = (v.tog && i > 0) ? i[0] : v.en;
    end
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 20 && sbq.size() > 0; k++) begin
      @(negedge clk);
      #1;
    end
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL %s: %0d expected outputs never appeared, required 0", name, sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            en len bad gaps tog pat nout cause
    tbl[0]  = '{1, 4,  0, 0, 0, 0, 3, 2'b00};  // good packet
    tbl[1]  = '{1, 4,  1, 0, 0, 0, 2, 2'b01};  // corrupted CRC
    tbl[2]  = '{1, 1,  0, 0, 0, 1, 0, 2'b10};  // runt
    tbl[3]  = '{1, 3,  0, 0, 0, 1, 2, 2'b00};  // back-to-back after runt
    tbl[4]  = '{1, 8,  0, 0, 0, 1, 7, 2'b00};  // exactly max length
    tbl[5]  = '{1, 12, 0, 0, 0, 1, 7, 2'b11};  // over-length, drop through TLAST
    tbl[6]  = '{1, 5,  0, 0, 0, 1, 4, 2'b00};
    tbl[7]  = '{0, 4,  0, 1, 1, 1, 4, 2'b00};  // CRC off, bubbles, cfg toggling
    tbl[8]  = '{0, 1,  0, 0, 0, 1, 1, 2'b00};  // CRC off single beat
    tbl[9]  = '{1, 2,  0, 0, 0, 1, 1, 2'b00};
    tbl[10] = '{1, 2,  1, 0, 0, 1, 0, 2'b01};
    tbl[11] = '{0, 12, 0, 0, 0, 1, 8, 2'b11};  // CRC off over-length
    tbl[12] = '{1, 6,  0, 1, 0, 1, 5, 2'b00};

    #3;
    chk("rst_tvalid", {31'b0, m_valid}, 32'h0);
    chk("rst_tdata", m_data, 32'h0);
    chk("rst_tlast", {31'b0, m_last}, 32'h0);
    chk("rst_tabort", {31'b0, m_abort}, 32'h0);
    chk("rst_err_count", {16'b0, err_count}, 32'h0);
    chk("rst_cause", {30'b0, cause}, 32'h0);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    idle_beat();

    for (int k = 0; k < 13; k++) send_pkt(tbl[k]);
    idle_beat();
    drain("table_drain");

    // Reset while a word is held: outputs clear asynchronously, nothing is emitted.
    @(negedge clk);
    s_valid = 1'b1; s_data = 32'hDEAD_BEEF; s_last = 1'b0; cfg = 1'b1;
    idle_beat();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_tvalid", {31'b0, m_valid}, 32'h0);
    chk("midrst_tdata", m_data, 32'h0);
    chk("midrst_tlast", {31'b0, m_last}, 32'h0);
    chk("midrst_tabort", {31'b0, m_abort}, 32'h0);
    chk("midrst_err_count", {16'b0, err_count}, 32'h0);
    chk("midrst_cause", {30'b0, cause}, 32'h0);
    exp_err = '0;
    @(negedge clk);
    rst_n = 1'b1;
    send_pkt(tbl[0]);
    idle_beat();
    drain("post_reset_drain");

    // Saturation: back-to-back runts.
    for (int k = 0; k < 65536; k++) begin
      sbq.push_back('{1'b1, 32'h0, 1'b0, 2'b10});
      @(negedge clk);
      s_valid = 1'b1; s_data = k; s_last = 1'b1; cfg = 1'b1;
    end
    idle_beat();
    drain("saturation_drain");
    chk("err_count_saturated", {16'b0, err_count}, 32'h0000_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
